hack_uart_tx: RTL and testbench

//  Memory-mapped serial transmitter on the Computer's data-memory write port, downstream of the CPU.

---
 rtl/hack_io_pkg.sv | 14 +
 rtl/hack_byte_fifo.sv | 49 ++++
 rtl/hack_uart_tx.sv | 153 +++++++++++++++
 tb/tb_hack_uart_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hack_io_pkg.sv
// Shared definitions for the Hack memory-mapped I/O blocks: default addresses,
// status bit positions and the serial transmitter state type.
package hack_io_pkg;

  localparam logic [15:0] TX_ADDR_DEFAULT   = 16'h6001;
  localparam logic [15:0] STAT_ADDR_DEFAULT = 16'h6002;

  localparam int STAT_FULL_BIT    = 0;
  localparam int STAT_BUSY_BIT    = 1;
  localparam int STAT_OVERRUN_BIT = 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/hack_byte_fifo.sv
// Byte FIFO with power-of-two depth; a push while full is taken only when a pop
// happens on the same edge, so the occupancy stays unchanged in that case.
module hack_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hack_uart_tx.sv
// Memory-mapped 8N1 transmitter on the Hack data-memory write port, with a
// status word (FULL, BUSY, sticky OVERRUN) for the top-level read mux.
//
// state | meaning
// IDLE  | line high; pops the next byte as soon as the FIFO holds one
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high) for one bit time
module hack_uart_tx
  import hack_io_pkg::*;
#(
  parameter logic [15:0] TX_ADDR      = TX_ADDR_DEFAULT,
  parameter logic [15:0] STAT_ADDR    = STAT_ADDR_DEFAULT,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic        stat_sel,
  output logic [15:0] stat_data,
  output logic        tx,
  output logic        tx_busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          tx_next;
  logic          pop;
  logic          overrun;

  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic push_req;
  logic clr_req;
  logic unused_hi;

  assign push_req  = writeM && (addressM == TX_ADDR);
  assign clr_req   = writeM && (addressM == STAT_ADDR);
  assign stat_sel  = (addressM == STAT_ADDR);
  assign unused_hi = ^outM[15:8];

  always_comb begin
    stat_data                   = '0;
    stat_data[STAT_FULL_BIT]    = fifo_full;
    stat_data[STAT_BUSY_BIT]    = tx_busy;
    stat_data[STAT_OVERRUN_BIT] = overrun;
  end

  hack_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (outM[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      tx      <= tx_next;
      tx_busy <= (state != IDLE) || (fifo_count != '0);
      if (push_req && fifo_full && !pop) overrun <= 1'b1;
      else if (clr_req)                  overrun <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          tx_next    = 1'b0;
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_next  = '0;
          tx_next    = shift[0];
          shift_next = {1'b0, shift[7:1]};
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            tx_next    = shift[0];
            shift_next = {1'b0, shift[7:1]};
            bit_next   = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hack_uart_tx.sv
// Bench for hack_uart_tx: frame-timeline reference model checked every cycle,
// a line decoder for received bytes, directed scenarios and random traffic.
module tb_hack_uart_tx;

  localparam int C = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic        stat_sel;
  logic [15:0] stat_data;
  logic        tx;
  logic        tx_busy;

  always #5 clk = ~clk;

  hack_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .addressM  (addressM),
    .outM      (outM),
    .writeM    (writeM),
    .stat_sel  (stat_sel),
    .stat_data (stat_data),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: a queue of pending bytes and a frame position t in 0..10*C-1.
  byte unsigned mq[$];
  bit           m_act = 1'b0;
  int           m_t   = 0;
  logic [7:0]   m_cur = 8'h00;
  bit           m_ovr = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_tx  = 1'b1;
  bit           chk_en = 1'b0;

  function automatic bit frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return b[j-1];
  endfunction

  always @(posedge clk) begin
    bit pop_now;
    if (reset === 1'b1) begin
      mq.delete();
      m_act = 0; m_t = 0; m_ovr = 0; m_busy = 0; m_tx = 1;
    end else begin
      m_busy  = m_act || (mq.size() != 0);
      pop_now = !m_act && (mq.size() != 0);
      if (m_act) begin
        m_t++;
        if (m_t == 10*C) m_act = 0;
      end else if (pop_now) begin
        m_cur = mq.pop_front();
        m_act = 1;
        m_t   = 0;
      end
      if (writeM && addressM == 16'h6001) begin
        if (mq.size() < D || pop_now) mq.push_back(outM[7:0]);
        else m_ovr = 1;
      end else if (writeM && addressM == 16'h6002) begin
        m_ovr = 0;
      end
      m_tx = m_act ? frame_bit(m_cur, m_t / C) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx", 16'(tx), 16'(m_tx));
      chk("tx_busy", 16'(tx_busy), 16'(m_busy));
      chk("stat_data", stat_data, {13'b0, m_ovr, m_busy, (mq.size() == D)});
      chk("stat_sel", 16'(stat_sel), 16'(addressM == 16'h6002));
    end
  end

  // Line decoder: samples mid-bit after seeing the start bit.
  int           rx_cnt = -1;
  logic [7:0]   rx_sh  = 8'h00;
  byte unsigned rx_q[$];

  always @(negedge clk) begin
    if (reset === 1'b1) rx_cnt = -1;
    else if (rx_cnt < 0) begin
      if (tx === 1'b0) rx_cnt = 0;
    end else begin
      rx_cnt++;
      if (rx_cnt % C == C/2 && rx_cnt / C >= 1 && rx_cnt / C <= 8)
        rx_sh[rx_cnt/C - 1] = tx;
      if (rx_cnt == 9*C + C/2) begin
        rx_q.push_back(rx_sh);
        rx_cnt = -1;
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addressM = a; outM = d; writeM = 1'b1;
    @(posedge clk); #2;
    writeM = 1'b0; addressM = 16'h0000; outM = 16'h0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_rx(input int n, input int base);
    chk("rx_count", 16'(rx_q.size()), 16'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      chk("rx_byte", {8'h00, rx_q[i]}, 16'(base + i));
  endtask

  logic [9:0] pat;

  initial begin
    reset = 1'b1; writeM = 1'b0; addressM = 16'h0000; outM = 16'h0000;
    idle(3);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_tx", 16'(tx), 16'h0001);
    chk("rst_busy", 16'(tx_busy), 16'h0000);
    chk("rst_stat", stat_data, 16'h0000);
    idle(1);

    // Single frame of 0x41: start, 1,0,0,0,0,0,1,0, stop.
    pat = 10'b1010000010;
    wr(16'h6001, 16'hAB41);
    @(negedge clk);
    chk("t1_pre_tx", 16'(tx), 16'h0001);
    for (int i = 0; i < 10*C; i++) begin
      @(negedge clk);
      chk("t1_tx", 16'(tx), 16'(pat[i/C]));
      chk("t1_busy", 16'(tx_busy), 16'h0001);
    end
    @(negedge clk);
    chk("t1_tx_end", 16'(tx), 16'h0001);
    @(negedge clk);
    chk("t1_busy_end", 16'(tx_busy), 16'h0000);
    idle(2);

    // Five back-to-back stores all make it out.
    rx_q.delete();
    for (int i = 1; i <= 5; i++) wr(16'h6001, 16'(i));
    idle(5*(10*C+2) + 8);
    chk_rx(5, 1);
    chk("t2_ovr", 16'(stat_data[2]), 16'h0000);

    // Six stores: the sixth overruns; clear via status store.
    rx_q.delete();
    for (int i = 0; i < 6; i++) wr(16'h6001, 16'(16'h0010 + i));
    @(negedge clk);
    chk("t3_stat_full", stat_data, 16'h0007);
    wr(16'h6002, 16'h0000);
    @(negedge clk);
    chk("t3_stat_clr", stat_data, 16'h0003);
    idle(5*(10*C+2) + 8);
    chk_rx(5, 16'h10);

    // Reset in the middle of the data bits of 0x55.
    rx_q.delete();
    wr(16'h6001, 16'h0055);
    idle(12);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_tx", 16'(tx), 16'h0001);
    chk("t4_stat", stat_data, 16'h0000);
    @(posedge clk); #2;
    reset = 1'b0;
    idle(60);
    chk("t4_rx_none", 16'(rx_q.size()), 16'h0000);

    // Stores elsewhere do nothing; status select tracks the address.
    rx_q.delete();
    wr(16'h6000, 16'h00AA);
    wr(16'h6003, 16'h0055);
    addressM = 16'h6002;
    @(negedge clk);
    chk("t5_sel_stat", 16'(stat_sel), 16'h0001);
    #1 addressM = 16'h6001;
    #1 chk("t5_sel_tx", 16'(stat_sel), 16'h0000);
    addressM = 16'h0000;
    idle(50);
    chk("t5_rx_none", 16'(rx_q.size()), 16'h0000);
    chk("t5_busy", 16'(tx_busy), 16'h0000);

    // Full FIFO, push on the edge the next byte is popped: accepted, no overrun.
    wr(16'h6001, 16'h00C3);
    for (int i = 1; i <= 4; i++) wr(16'h6001, 16'(i));
    idle(10*C - 3);
    wr(16'h6001, 16'h00EE);
    @(negedge clk);
    chk("t6_stat", stat_data, 16'h0003);
    idle(6*(10*C+2) + 8);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1; idle(1); reset = 1'b0;
      end else if (r < 3) wr(16'h6001, 16'($urandom));
      else if (r == 3) wr(16'h6002, 16'($urandom));
      else if (r == 4) wr(16'($urandom), 16'($urandom));
      else if (r == 5) begin
        addressM = 16'h6002; idle(1); addressM = 16'h0000;
      end else idle(1);
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
